// File: rtl/issue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : issue_ctrl_pkg
//  Purpose  : Shared types for the issue/hazard controller. Provides the
//             pipeline slot record, the MU state encoding, the forwarding
//             select encoding and small hazard helper functions.
//  Revision : 1.0  initial release
// ============================================================================
package issue_ctrl_pkg;

   // One in-flight writer tracked in the E or M slot
   typedef struct packed {
      logic       valid;
      logic [4:0] dst;
      logic       regwrite;
      logic       ismem;
   } slot_t;

   localparam slot_t SLOT_EMPTY = '0;

   // Multi-cycle unit sequencing states
   typedef enum logic [1:0] {
      MU_IDLE = 2'd0,
      MU_BUSY = 2'd1,
      MU_WB   = 2'd2
   } mu_state_t;

   // Operand source select
   typedef logic [1:0] fwd_sel_t;
   localparam fwd_sel_t FWD_REG = 2'd0;
   localparam fwd_sel_t FWD_E   = 2'd1;
   localparam fwd_sel_t FWD_M   = 2'd2;

   // A slot produces the value of rs (x0 never matches)
   function automatic logic slot_hit(input slot_t s, input logic [4:0] rs);
      return s.valid & s.regwrite & (s.dst == rs) & (rs != 5'd0);
   endfunction

   // E has priority; a load in E cannot forward, so fall back to M
   function automatic fwd_sel_t fwd_pick(input logic e_hit, input logic e_ismem,
                                         input logic m_hit);
      if (e_hit & ~e_ismem) begin
         return FWD_E;
      end else if (m_hit) begin
         return FWD_M;
      end
      return FWD_REG;
   endfunction

endpackage
`default_nettype wire

// File: rtl/issue_ctrl_mu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : issue_ctrl_mu_seq
//  Purpose  : Multi-cycle unit sequencer. Runs the IDLE/BUSY/WB state
//             machine with its latency counter, owns the pending-writer
//             bitmap and arbitrates the regfile write port against M.
//  Revision : 1.0  initial release
// ============================================================================
module issue_ctrl_mu_seq
   import issue_ctrl_pkg::*;
#(
   parameter int MU_LAT = 4,
   parameter int NREG   = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start_i,     // MU instruction issues this cycle
   input  logic [4:0]      rd_i,        // its destination
   input  logic            wb_block_i,  // M slot owns the write port
   output logic [NREG-1:0] pend_o,
   output logic            mu_start_o,
   output logic            mu_busy_o,
   output logic            mu_wb_o,
   output logic [4:0]      mu_dst_o
);

   localparam int CW = $clog2(MU_LAT);

   mu_state_t       state_q, state_d;
   logic [CW-1:0]   cnt_q,   cnt_d;
   logic [NREG-1:0] pend_q,  pend_d;
   logic [4:0]      dst_q,   dst_d;
   logic            start_q, start_d;
   logic            wb_w;

   // State register; an asynchronous reset aborts any operation in flight
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= MU_IDLE;
         cnt_q   <= '0;
         pend_q  <= '0;
         dst_q   <= 5'd0;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         dst_q   <= dst_d;
         start_q <= start_d;
      end
   end

   // Next-state: the counter runs regardless of memory stalls, and WB
   // waits one cycle at a time while M holds the write port
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      dst_d   = dst_q;
      start_d = 1'b0;
      wb_w    = 1'b0;
      case (state_q)
         MU_IDLE: begin
            if (start_i) begin
               state_d = MU_BUSY;
               cnt_d   = CW'(MU_LAT - 1);
               dst_d   = rd_i;
               start_d = 1'b1;
               if (rd_i != 5'd0) begin
                  pend_d[rd_i] = 1'b1;
               end
            end
         end
         MU_BUSY: begin
            cnt_d = cnt_q - CW'(1);
            // counter reaches zero on this edge
            if (cnt_q == CW'(1)) begin
               state_d = MU_WB;
            end
         end
         MU_WB: begin
            if (!wb_block_i) begin
               wb_w            = 1'b1;
               pend_d[dst_q]   = 1'b0;
               state_d         = MU_IDLE;
            end
         end
         default: begin
            state_d = MU_IDLE;
         end
      endcase
   end

   assign pend_o     = pend_q;
   assign mu_start_o = start_q;
   assign mu_busy_o  = (state_q != MU_IDLE);
   assign mu_wb_o    = wb_w;
   assign mu_dst_o   = dst_q;

endmodule
`default_nettype wire

// File: rtl/issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : issue_ctrl
//  Purpose  : Issue/hazard controller beside decode. Tracks E/M writers and
//             the multi-cycle unit, decides issue vs stall and selects the
//             operand forwarding source.
//  Options  : ISSUE_FWD_EN - when defined, E/M results are forwarded; when
//             undefined, fwd1/fwd2 are 0 and any E/M producer match stalls.
//  Revision : 1.0  initial release
// ============================================================================
module issue_ctrl
   import issue_ctrl_pkg::*;
#(
   parameter int MU_LAT = 4,
   parameter int NREG   = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   input  logic [4:0] in_rs1,
   input  logic [4:0] in_rs2,
   input  logic [4:0] in_rd,
   input  logic       in_regwrite,
   input  logic       in_ismem,
   input  logic       in_ismulti,
   input  logic       branch,
   input  logic       stopm,
   output logic       stall_d,
   output logic       issue,
   output logic [1:0] fwd1,
   output logic [1:0] fwd2,
   output logic       mu_start,
   output logic       mu_busy,
   output logic       mu_wb,
   output logic [4:0] mu_dst
);

   slot_t           e_q, e_d, m_q, m_d;
   logic [NREG-1:0] pend;
   logic            e_hit1, e_hit2, m_hit1, m_hit2;
   logic            haz_lu, haz_mu, haz_waw, haz_st, haz_raw;
   logic            unused_m_ismem;

   assign e_hit1 = slot_hit(e_q, in_rs1);
   assign e_hit2 = slot_hit(e_q, in_rs2);
   assign m_hit1 = slot_hit(m_q, in_rs1);
   assign m_hit2 = slot_hit(m_q, in_rs2);

   // A load in M has already delivered its data, so only E's flag matters
   assign unused_m_ismem = m_q.ismem;

   assign haz_lu  = e_q.ismem & (e_hit1 | e_hit2);
   assign haz_mu  = ((in_rs1 != 5'd0) & pend[in_rs1]) |
                    ((in_rs2 != 5'd0) & pend[in_rs2]);
   assign haz_waw = in_regwrite & (in_rd != 5'd0) & pend[in_rd];
   assign haz_st  = in_ismulti & mu_busy;

`ifdef ISSUE_FWD_EN
   assign haz_raw = 1'b0;
   assign fwd1    = fwd_pick(e_hit1, e_q.ismem, m_hit1);
   assign fwd2    = fwd_pick(e_hit2, e_q.ismem, m_hit2);
`else
   // Without bypass paths a reader waits until the producer leaves M
   assign haz_raw = e_hit1 | e_hit2 | m_hit1 | m_hit2;
   assign fwd1    = FWD_REG;
   assign fwd2    = FWD_REG;
`endif

   assign stall_d = in_valid & (haz_lu | haz_mu | haz_waw | haz_st | haz_raw);
   assign issue   = in_valid & ~stall_d & ~stopm & ~branch;

   // E/M slot advance; MU ops and squashed or stalled slots enter E as bubbles
   always_comb begin
      e_d = e_q;
      m_d = m_q;
      if (!stopm) begin
         m_d = e_q;
         e_d = SLOT_EMPTY;
         if (issue & ~in_ismulti) begin
            e_d.valid    = 1'b1;
            e_d.dst      = in_rd;
            e_d.regwrite = in_regwrite;
            e_d.ismem    = in_ismem;
         end
      end
   end

   // Slot registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         e_q <= SLOT_EMPTY;
         m_q <= SLOT_EMPTY;
      end else begin
         e_q <= e_d;
         m_q <= m_d;
      end
   end

   issue_ctrl_mu_seq #(
      .MU_LAT (MU_LAT),
      .NREG   (NREG)
   ) u_mu_seq (
      .clk        (clk),
      .reset      (reset),
      .start_i    (issue & in_ismulti),
      .rd_i       (in_rd),
      .wb_block_i (m_q.valid & m_q.regwrite),
      .pend_o     (pend),
      .mu_start_o (mu_start),
      .mu_busy_o  (mu_busy),
      .mu_wb_o    (mu_wb),
      .mu_dst_o   (mu_dst)
   );

endmodule
`default_nettype wire

// File: tb/tb_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_issue_ctrl
//  Purpose  : Self-checking bench for issue_ctrl: vector table, directed
//             multi-cycle sequences and a randomized run against a
//             behavioural model of the issue rules.
//  Options  : ISSUE_FWD_EN selects the expected forwarding behaviour.
//  Revision : 1.0  initial release
// ============================================================================
module tb_issue_ctrl;

   localparam int MU_LAT = 4;
`ifdef ISSUE_FWD_EN
   localparam bit FWD_ON = 1'b1;
`else
   localparam bit FWD_ON = 1'b0;
`endif

   logic       clk;
   logic       reset;
   logic       in_valid, in_regwrite, in_ismem, in_ismulti, branch, stopm;
   logic [4:0] in_rs1, in_rs2, in_rd;
   logic       stall_d, issue, mu_start, mu_busy, mu_wb;
   logic [1:0] fwd1, fwd2;
   logic [4:0] mu_dst;

   issue_ctrl #(.MU_LAT(MU_LAT), .NREG(32)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_rs1(in_rs1),
      .in_rs2(in_rs2), .in_rd(in_rd), .in_regwrite(in_regwrite),
      .in_ismem(in_ismem), .in_ismulti(in_ismulti), .branch(branch),
      .stopm(stopm), .stall_d(stall_d), .issue(issue), .fwd1(fwd1),
      .fwd2(fwd2), .mu_start(mu_start), .mu_busy(mu_busy), .mu_wb(mu_wb),
      .mu_dst(mu_dst)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rd, input logic rw, input logic mem,
                        input logic mul, input logic br, input logic sm);
      in_valid = v; in_rs1 = r1; in_rs2 = r2; in_rd = rd; in_regwrite = rw;
      in_ismem = mem; in_ismulti = mul; branch = br; stopm = sm;
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // ---------------- behavioural model ----------------
   typedef struct packed { logic v; logic [4:0] dst; logic rw; logic mem; } ins_t;
   ins_t pipe[$];          // pipe[0] = youngest (E), pipe[1] = M
   bit         mu_act;
   int         mu_el;      // cycles elapsed since the MU op issued
   logic [4:0] mu_d, mu_last;
   logic       x_stall, x_issue, x_start, x_busy, x_wb;
   logic [1:0] x_f1, x_f2;

   task automatic mdl_reset();
      pipe.delete();
      pipe.push_back('0);
      pipe.push_back('0);
      mu_act = 0; mu_el = 0; mu_d = 5'd0; mu_last = 5'd0;
   endtask

   function automatic logic produces(ins_t s, logic [4:0] rs);
      return s.v && s.rw && s.dst == rs && rs != 5'd0;
   endfunction

   function automatic logic waits_mu(logic [4:0] r);
      return mu_act && r != 5'd0 && mu_d == r;
   endfunction

   task automatic mdl_eval();
      logic [4:0] rs[2];
      logic [1:0] f[2];
      logic       hz;
      rs[0] = in_rs1; rs[1] = in_rs2;
      hz = 1'b0;
      for (int k = 0; k < 2; k++) begin
         logic he, hm;
         he = produces(pipe[0], rs[k]);
         hm = produces(pipe[1], rs[k]);
         if (he && pipe[0].mem) hz = 1'b1;
         if (waits_mu(rs[k])) hz = 1'b1;
         if (!FWD_ON && (he || hm)) hz = 1'b1;
         f[k] = !FWD_ON ? 2'd0 : (he && !pipe[0].mem) ? 2'd1 : hm ? 2'd2 : 2'd0;
      end
      if (in_regwrite && waits_mu(in_rd)) hz = 1'b1;
      if (in_ismulti && mu_act) hz = 1'b1;
      x_stall = in_valid && hz;
      x_issue = in_valid && !x_stall && !stopm && !branch;
      x_f1    = f[0];
      x_f2    = f[1];
      x_busy  = mu_act;
      x_start = mu_act && mu_el == 1;
      x_wb    = mu_act && mu_el >= MU_LAT && !(pipe[1].v && pipe[1].rw);
   endtask

   task automatic mdl_update();
      ins_t n;
      if (mu_act) begin
         if (x_wb) mu_act = 0;
         else if (mu_el < MU_LAT) mu_el++;
      end
      if (x_issue && in_ismulti) begin
         mu_act = 1; mu_el = 1; mu_d = in_rd; mu_last = in_rd;
      end
      if (!stopm) begin
         n = '0;
         if (x_issue && !in_ismulti) begin
            n.v = 1'b1; n.dst = in_rd; n.rw = in_regwrite; n.mem = in_ismem;
         end
         pipe.push_front(n);
         void'(pipe.pop_back());
      end
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      mdl_reset();
      next_cycle();
      reset = 1'b0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic v; logic [4:0] r1, r2, rd; logic rw, mem, mul, br, sm;
      logic st, is; logic [1:0] f1, f2;
   } vec_t;

   function automatic vec_t mk(logic v, logic [4:0] r1, logic [4:0] r2, logic [4:0] rd,
                               logic rw, logic mem, logic mul, logic br, logic sm,
                               logic st, logic is, logic [1:0] f1, logic [1:0] f2);
      vec_t t;
      t.v = v; t.r1 = r1; t.r2 = r2; t.rd = rd; t.rw = rw; t.mem = mem;
      t.mul = mul; t.br = br; t.sm = sm; t.st = st; t.is = is; t.f1 = f1; t.f2 = f2;
      return t;
   endfunction

   localparam int NV = 14;
   vec_t tbl[NV];

   initial begin
      logic [1:0] f_one, f_two;
      f_one = FWD_ON ? 2'd1 : 2'd0;
      f_two = FWD_ON ? 2'd2 : 2'd0;
      // forwarding chain on x5
      tbl[0]  = mk(1, 5'd1,  5'd2, 5'd5,  1, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0);
      tbl[1]  = mk(1, 5'd5,  5'd5, 5'd6,  1, 0, 0, 0, 0, !FWD_ON, FWD_ON, f_one, f_one);
      tbl[2]  = mk(1, 5'd5,  5'd0, 5'd10, 1, 0, 0, 0, 0, !FWD_ON, FWD_ON, f_two, 2'd0);
      tbl[3]  = mk(0, 5'd5,  5'd6, 5'd0,  0, 0, 0, 0, 0, 0, 0, 2'd0, f_two);
      tbl[4]  = mk(0, 5'd0,  5'd0, 5'd0,  0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0);
      // load-use on x7
      tbl[5]  = mk(1, 5'd1,  5'd0, 5'd7,  1, 1, 0, 0, 0, 0, 1, 2'd0, 2'd0);
      tbl[6]  = mk(1, 5'd7,  5'd0, 5'd8,  1, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0);
      tbl[7]  = mk(1, 5'd7,  5'd0, 5'd8,  1, 0, 0, 0, 0, !FWD_ON, FWD_ON, f_two, 2'd0);
      tbl[8]  = mk(0, 5'd0,  5'd0, 5'd0,  0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0);
      tbl[9]  = mk(0, 5'd0,  5'd0, 5'd0,  0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0);
      // squashed writer leaves no hazard behind
      tbl[10] = mk(1, 5'd1,  5'd2, 5'd11, 1, 0, 0, 1, 0, 0, 0, 2'd0, 2'd0);
      tbl[11] = mk(1, 5'd11, 5'd0, 5'd12, 1, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0);
      tbl[12] = mk(0, 5'd0,  5'd0, 5'd0,  0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0);
      tbl[13] = mk(0, 5'd0,  5'd0, 5'd0,  0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0);
   end

   // ---------------- test sequence ----------------
   initial begin
      reset = 1'b1;
      idle();
      #1;
      do_reset();

      // reset state
      @(negedge clk);
      chk("rst stall_d", stall_d, 0);  chk("rst issue", issue, 0);
      chk("rst fwd1", fwd1, 0);        chk("rst fwd2", fwd2, 0);
      chk("rst mu_start", mu_start, 0); chk("rst mu_busy", mu_busy, 0);
      chk("rst mu_wb", mu_wb, 0);      chk("rst mu_dst", mu_dst, 0);
      next_cycle();

      for (int i = 0; i < NV; i++) begin
         drive(tbl[i].v, tbl[i].r1, tbl[i].r2, tbl[i].rd, tbl[i].rw,
               tbl[i].mem, tbl[i].mul, tbl[i].br, tbl[i].sm);
         @(negedge clk);
         chk($sformatf("vec%0d stall_d", i), stall_d, tbl[i].st);
         chk($sformatf("vec%0d issue", i),   issue,   tbl[i].is);
         chk($sformatf("vec%0d fwd1", i),    fwd1,    tbl[i].f1);
         chk($sformatf("vec%0d fwd2", i),    fwd2,    tbl[i].f2);
         next_cycle();
      end

      // MU latency: mul x9, dependent reader waits cycles 1-4
      do_reset();
      drive(1, 5'd1, 5'd2, 5'd9, 1, 0, 1, 0, 0);
      @(negedge clk);
      chk("mu c0 issue", issue, 1); chk("mu c0 busy", mu_busy, 0); chk("mu c0 start", mu_start, 0);
      next_cycle();
      drive(1, 5'd9, 5'd0, 5'd13, 1, 0, 0, 0, 0);
      @(negedge clk);
      chk("mu c1 start", mu_start, 1); chk("mu c1 busy", mu_busy, 1);
      chk("mu c1 dst", mu_dst, 9);     chk("mu c1 stall", stall_d, 1);
      next_cycle();
      for (int c = 2; c <= 3; c++) begin
         @(negedge clk);
         chk($sformatf("mu c%0d stall", c), stall_d, 1);
         chk($sformatf("mu c%0d wb", c), mu_wb, 0);
         chk($sformatf("mu c%0d start", c), mu_start, 0);
         next_cycle();
      end
      @(negedge clk);
      chk("mu c4 stall", stall_d, 1); chk("mu c4 wb", mu_wb, 1);
      next_cycle();
      @(negedge clk);
      chk("mu c5 stall", stall_d, 0); chk("mu c5 issue", issue, 1); chk("mu c5 busy", mu_busy, 0);
      next_cycle();

      // WB conflict with an M-slot writer, plus structural and WAW stalls
      do_reset();
      drive(1, 5'd1, 5'd2, 5'd9, 1, 0, 1, 0, 0);
      @(negedge clk); chk("wbc c0 issue", issue, 1); next_cycle();
      drive(1, 5'd1, 5'd2, 5'd15, 1, 0, 1, 0, 0);
      @(negedge clk); chk("wbc c1 struct stall", stall_d, 1); chk("wbc c1 issue", issue, 0); next_cycle();
      drive(1, 5'd1, 5'd2, 5'd14, 1, 0, 0, 0, 0);
      @(negedge clk); chk("wbc c2 issue", issue, 1); next_cycle();
      drive(1, 5'd1, 5'd2, 5'd9, 1, 0, 0, 0, 0);
      @(negedge clk); chk("wbc c3 waw stall", stall_d, 1); next_cycle();
      drive(1, 5'd9, 5'd0, 5'd13, 1, 0, 0, 0, 0);
      @(negedge clk);
      chk("wbc c4 wb", mu_wb, 0); chk("wbc c4 busy", mu_busy, 1); chk("wbc c4 stall", stall_d, 1);
      next_cycle();
      @(negedge clk); chk("wbc c5 wb", mu_wb, 1); chk("wbc c5 stall", stall_d, 1); next_cycle();
      @(negedge clk); chk("wbc c6 stall", stall_d, 0); chk("wbc c6 issue", issue, 1); next_cycle();

      // stopm freezes E/M but not the MU counter
      do_reset();
      drive(1, 5'd1, 5'd2, 5'd5, 1, 0, 0, 0, 0);
      @(negedge clk); chk("stp c0 issue", issue, 1); next_cycle();
      drive(1, 5'd1, 5'd2, 5'd9, 1, 0, 1, 0, 0);
      @(negedge clk); chk("stp c1 issue", issue, 1); next_cycle();
      drive(1, 5'd5, 5'd0, 5'd16, 1, 0, 0, 0, 1);
      for (int c = 2; c <= 4; c++) begin
         @(negedge clk);
         chk($sformatf("stp c%0d issue", c), issue, 0);
         chk($sformatf("stp c%0d fwd1", c), fwd1, FWD_ON ? 2'd2 : 2'd0);
         chk($sformatf("stp c%0d stall", c), stall_d, !FWD_ON);
         chk($sformatf("stp c%0d busy", c), mu_busy, 1);
         next_cycle();
      end
      idle();
      @(negedge clk); chk("stp c5 wb held", mu_wb, 0); chk("stp c5 busy", mu_busy, 1); next_cycle();
      @(negedge clk); chk("stp c6 wb", mu_wb, 1); next_cycle();
      @(negedge clk); chk("stp c7 busy", mu_busy, 0); next_cycle();

      // asynchronous reset while MU busy
      do_reset();
      drive(1, 5'd1, 5'd2, 5'd9, 1, 0, 1, 0, 0);
      @(negedge clk); chk("ar c0 issue", issue, 1); next_cycle();
      drive(1, 5'd9, 5'd0, 5'd13, 1, 0, 0, 0, 0);
      @(negedge clk);
      chk("ar c1 stall", stall_d, 1); chk("ar c1 busy", mu_busy, 1);
      #1 reset = 1'b1;
      #1;
      chk("ar busy", mu_busy, 0); chk("ar stall", stall_d, 0);
      chk("ar start", mu_start, 0); chk("ar dst", mu_dst, 0);
      next_cycle();
      reset = 1'b0;
      @(negedge clk);
      chk("ar post stall", stall_d, 0); chk("ar post issue", issue, 1); chk("ar post busy", mu_busy, 0);
      next_cycle();

      // randomized run against the model
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         int kind;
         kind = int'($urandom_range(0, 9));
         drive($urandom_range(0, 99) < 85, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), $urandom_range(0, 9) < 8,
               kind == 1 || kind == 2, kind == 0,
               $urandom_range(0, 9) == 0, $urandom_range(0, 99) < 15);
         @(negedge clk);
         mdl_eval();
         chk("rnd stall_d", stall_d, x_stall);
         chk("rnd issue", issue, x_issue);
         chk("rnd fwd1", fwd1, x_f1);
         chk("rnd fwd2", fwd2, x_f2);
         chk("rnd mu_start", mu_start, x_start);
         chk("rnd mu_busy", mu_busy, x_busy);
         chk("rnd mu_wb", mu_wb, x_wb);
         chk("rnd mu_dst", mu_dst, mu_last);
         @(posedge clk);
         mdl_update();
         #1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/issue_ctrl.md
Name: issue_ctrl

Overview:
Issue/hazard controller sitting beside the decode stage. Tracks in-flight writers in the E and M slots and one multi-cycle unit (MU). Decides each cycle whether the decoded instruction issues or stalls, and selects the operand forwarding source. Sequences the MU (start, busy count, writeback-port arbitration against the M stage).

Parameters:
MU_LAT, 4, MU execute latency in cycles (≥2) from issue to result ready
NREG, 32, architectural register count; pending bitmap width

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-high reset
in_valid  input  1  decode holds a valid instruction
in_rs1  input  5  source reg 1
in_rs2  input  5  source reg 2
in_rd  input  5  destination reg
in_regwrite  input  1  instruction writes in_rd
in_ismem  input  1  instruction is a load (result available after M)
in_ismulti  input  1  instruction executes in MU
branch  input  1  redirect; current decode instruction is squashed
stopm  input  1  memory stage stall; freezes E/M slots
stall_d  output  1  decode must hold (hazard)
issue  output  1  instruction accepted this cycle
fwd1  output  2  rs1 source: 0 regfile, 1 E slot, 2 M slot
fwd2  output  2  rs2 source, same encoding
mu_start  output  1  one-cycle pulse, MU begins
mu_busy  output  1  MU occupied (BUSY or WB)
mu_wb  output  1  MU result owns regfile write port this cycle
mu_dst  output  5  MU destination register

Behaviour:
- Reset (async): E/M slots invalid, pend bitmap 0, MU state IDLE, counter 0, mu_dst 0. All outputs 0.
- Register 0 never creates hazards or forwarding (rs==0 → fwd 0, no stall).
- Hazards, combinational, for rsX in {rs1, rs2} when in_valid:
  - load-use: E.valid & E.regwrite & E.ismem & rsX==E.dst.
  - MU pending: pend[rsX].
  - WAW: in_regwrite & pend[in_rd] & in_rd≠0.
  - structural: in_ismulti & mu_busy.
  - stall_d = OR of the above.
- issue = in_valid & ~stall_d & ~stopm & ~branch.
- Forwarding: E match (valid, regwrite, ~ismem) → 1; else M match (valid, regwrite) → 2; else 0. E has priority over M.
- Slot advance, when ~stopm, at each edge:
  - M ← E.
  - E ← issued non-MU instruction, or bubble when not issued, issued ismulti, or branch.
  - When stopm, E and M hold.
- MU FSM:
  - IDLE → BUSY on issue & in_ismulti. Same edge: mu_start pulse, mu_dst←in_rd, pend[in_rd]←1 (if rd≠0), counter←MU_LAT-1.
  - BUSY: decrement counter every cycle, independent of stopm. When counter reaches 0, go to WB.
  - WB: mu_wb=1 only if ~(M.valid & M.regwrite); on that cycle clear pend[mu_dst] and return to IDLE. Otherwise hold in WB, deferring one cycle at a time.
  - No new MU issue is possible while in WB (structural stall).
- branch does not cancel an MU op already started. branch and issue in the same cycle → squashed, no state change from decode.
- Simultaneous pend clear (WB) and set (new issue) cannot occur: structural stall prevents it.
- Reset mid-operation aborts the MU op and clears pend.

Optional Feature:
ISSUE_FWD_EN
- Defined: forwarding as above.
- Undefined: fwd1/fwd2 tied 0. Any rsX matching a valid regwriting E or M slot also stalls (stall until writeback).

Decomposition:
- In pipes package: typedef slot_t {valid, dst[4:0], regwrite, ismem}; enum mu_state_t {MU_IDLE, MU_BUSY, MU_WB}; fwd_sel_t 2-bit with FWD_REG/FWD_E/FWD_M constants.
- One sub-module, mu_seq: MU FSM + counter + pend bitmap, exposing pend vector and mu_* outputs.

Test Plan:
- Forwarding: issue add x5 (no stall), then sub x6,x5,x5 next cycle → fwd1=fwd2=1, issue=1. Third instruction reads x5 → fwd=2.
- Load-use: load x7, then add x8,x7,x0 → stall_d=1 for exactly 1 cycle, then fwd1=2, issue=1.
- MU with MU_LAT=4: mul x9 at cycle 0 → mu_start at edge 0; dependent reader of x9 stalls cycles 1-4; mu_wb at cycle 4 (M empty); reader issues at cycle 5.
- WB conflict: M slot holds regwrite at the MU's WB cycle → mu_wb deferred 1 cycle, pend[x9] still 1, and the reader of x9 stalls one extra cycle.
- Flush/stopm: branch=1 with in_valid → issue=0, E bubble. stopm=1 for 3 cycles → E/M hold, MU counter still decrements.
- Async reset asserted while in MU_BUSY → immediately mu_busy=0, pend=0, stall_d=0.
